// File: rtl/async_fifo_wptr_ctrl_if.sv
// async_fifo_wptr_ctrl_if: write-side client/RAM/synchroniser bundle for the FIFO write pointer controller
interface async_fifo_wptr_ctrl_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  winc;
    logic [ADDR_WIDTH:0]   wq2_rptr;
    logic                  wovf_clr;
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wen;
    logic                  wfull;
    logic                  walmost_full;
    logic [ADDR_WIDTH:0]   wlevel;
    logic                  woverflow;

    modport master (
        output winc, wq2_rptr, wovf_clr,
        input  wptr, waddr, wen, wfull, walmost_full, wlevel, woverflow
    );

    modport slave (
        input  winc, wq2_rptr, wovf_clr,
        output wptr, waddr, wen, wfull, walmost_full, wlevel, woverflow
    );
endinterface

// File: rtl/async_fifo_wptr_ctrl.sv
// async_fifo_wptr_ctrl: write-domain pointer, Gray publish and full/almost-full/level/overflow flags
module async_fifo_wptr_ctrl #(
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_MARGIN = 1
) (
    input logic                   wclk,
    input logic                   wrst_n,
    async_fifo_wptr_ctrl_if.slave bus
);
    localparam int A = ADDR_WIDTH;
    localparam int DEPTH = 1 << A;
    localparam logic [A:0] AF_TH = (A+1)'(DEPTH - AFULL_MARGIN);

    logic [A:0] wbin;
    logic [A:0] wbin_next;
    logic [A:0] wgray_next;
    logic [A:0] rbin;
    logic [A:0] level_next;
    logic [A:0] full_ptr;

    assign bus.waddr = wbin[A-1:0];

    // next pointer, Gray form, read-pointer decode and flag compare values
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= A; i++) rbin[i] = ^(bus.wq2_rptr >> i);
        bus.wen    = bus.winc & ~bus.wfull;
        wbin_next  = wbin + {{A{1'b0}}, bus.wen};
        wgray_next = wbin_next ^ (wbin_next >> 1);
        level_next = wbin_next - rbin;
        full_ptr   = {~bus.wq2_rptr[A:A-1], bus.wq2_rptr[A-2:0]};
    end

    // pointer and flags share one next-state compare so they never disagree
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin             <= '0;
            bus.wptr         <= '0;
            bus.wfull        <= 1'b0;
            bus.walmost_full <= 1'b0;
            bus.wlevel       <= '0;
            bus.woverflow    <= 1'b0;
        end else begin
            wbin             <= wbin_next;
            bus.wptr         <= wgray_next;
            bus.wfull        <= wgray_next == full_ptr;
            bus.walmost_full <= level_next >= AF_TH;
            bus.wlevel       <= level_next;
            bus.woverflow    <= (bus.winc & bus.wfull) | (bus.woverflow & ~bus.wovf_clr);
        end
    end
endmodule

// File: tb/tb_async_fifo_wptr_ctrl.sv
// tb_async_fifo_wptr_ctrl: scoreboard bench for the FIFO write pointer controller
module tb_async_fifo_wptr_ctrl;
    logic wclk;
    logic wrst_n;
    int   n_chk;
    int   n_err;

    async_fifo_wptr_ctrl_if #(.ADDR_WIDTH(3)) b3 ();
    async_fifo_wptr_ctrl_if #(.ADDR_WIDTH(2)) b2 ();
    async_fifo_wptr_ctrl_if #(.ADDR_WIDTH(4)) b4 ();

    async_fifo_wptr_ctrl #(.ADDR_WIDTH(3), .AFULL_MARGIN(1))  dut  (.wclk(wclk), .wrst_n(wrst_n), .bus(b3));
    async_fifo_wptr_ctrl #(.ADDR_WIDTH(2), .AFULL_MARGIN(3))  dut2 (.wclk(wclk), .wrst_n(wrst_n), .bus(b2));
    async_fifo_wptr_ctrl #(.ADDR_WIDTH(4), .AFULL_MARGIN(15)) dut4 (.wclk(wclk), .wrst_n(wrst_n), .bus(b4));

    typedef struct {
        logic [3:0] wptr;
        logic       full;
        logic       af;
        logic       ovf;
        logic [3:0] lvl;
    } exp_t;

    exp_t sb[$];
    int   wc;
    logic m_full;
    logic m_ovf;

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [3:0] gray4(input int v);
        logic [3:0] b;
        b = 4'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic inc, input int rc, input logic clr);
        exp_t e;
        logic acc;
        logic [3:0] prev;
        int lvl;
        b3.winc = inc;
        b3.wq2_rptr = gray4(rc);
        b3.wovf_clr = clr;
        #1;
        chk("wen", 32'(b3.wen), 32'(inc & ~m_full));
        chk("waddr", 32'(b3.waddr), wc % 8);
        acc = inc & ~m_full;
        m_ovf = (inc & m_full) | (m_ovf & ~clr);
        wc += int'(acc);
        lvl = wc - rc;
        m_full = lvl == 8;
        e = '{gray4(wc), m_full, lvl >= 7, m_ovf, 4'(lvl)};
        sb.push_back(e);
        prev = b3.wptr;
        @(posedge wclk);
        #1;
        e = sb.pop_front();
        chk("wptr", 32'(b3.wptr), 32'(e.wptr));
        chk("wfull", 32'(b3.wfull), 32'(e.full));
        chk("walmost_full", 32'(b3.walmost_full), 32'(e.af));
        chk("woverflow", 32'(b3.woverflow), 32'(e.ovf));
        chk("wlevel", 32'(b3.wlevel), 32'(e.lvl));
        chk("gray_step", 32'($countones(prev ^ b3.wptr) <= 1), 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wptr"}, 32'(b3.wptr), 0);
        chk({tag, "_waddr"}, 32'(b3.waddr), 0);
        chk({tag, "_wfull"}, 32'(b3.wfull), 0);
        chk({tag, "_walmost_full"}, 32'(b3.walmost_full), 0);
        chk({tag, "_wlevel"}, 32'(b3.wlevel), 0);
        chk({tag, "_woverflow"}, 32'(b3.woverflow), 0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        wc = 0;
        m_full = 1'b0;
        m_ovf = 1'b0;
        wrst_n = 1'b1;
        b3.winc = 1'b0; b3.wq2_rptr = '0; b3.wovf_clr = 1'b0;
        b2.winc = 1'b0; b2.wq2_rptr = '0; b2.wovf_clr = 1'b0;
        b4.winc = 1'b0; b4.wq2_rptr = '0; b4.wovf_clr = 1'b0;
        #1 wrst_n = 1'b0;
        #1 chk_reset("rst");
        @(negedge wclk) wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        for (int i = 0; i < 8; i++) step(1'b1, 0, 1'b0);
        chk("fill_wptr", 32'(b3.wptr), 32'b1100);
        chk("fill_wlevel", 32'(b3.wlevel), 8);
        step(1'b1, 0, 1'b0);
        step(1'b1, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b1, 0, 1'b1);
        chk("ovf_set_wins", 32'(b3.woverflow), 1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 1, 1'b0);
        chk("release_wlevel", 32'(b3.wlevel), 7);
        step(1'b1, 1, 1'b0);
        for (int r = 2; r <= 6; r++) step(1'b0, r, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, wc - 2, 1'b0);
        chk("wrap_wlevel", 32'(b3.wlevel), 3);
        chk("wrap_wfull", 32'(b3.wfull), 0);
        #2 wrst_n = 1'b0;
        #1 chk_reset("midrst");
        b3.winc = 1'b0;
        b3.wq2_rptr = '0;
        wc = 0;
        m_full = 1'b0;
        m_ovf = 1'b0;
        @(negedge wclk) wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        step(1'b1, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            b2.winc = 1'b1;
            b4.winc = 1'b1;
            @(posedge wclk);
            #1;
            chk("p2_af", 32'(b2.walmost_full), 1);
            chk("p2_full", 32'(b2.wfull), 32'(i >= 4));
            chk("p2_wlevel", 32'(b2.wlevel), (i >= 4) ? 4 : i);
            chk("p4_af", 32'(b4.walmost_full), 1);
            chk("p4_full", 32'(b4.wfull), 32'(i >= 16));
            chk("p4_wlevel", 32'(b4.wlevel), (i >= 16) ? 16 : i);
        end
        chk("p2_ovf", 32'(b2.woverflow), 1);
        chk("p4_ovf", 32'(b4.woverflow), 1);
        b2.winc = 1'b0;
        b4.winc = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
